fetch_unit: RTL

//   Instruction fetch stage directly upstream of the decoder.

---
 rtl/fetch_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the decoder. Holds a loadable program
//   memory and the fetch PC, and presents one instruction at a time on
//   inst_reg with a valid/ready handshake. The execute side can redirect the
//   PC (jump) or discard the next sequential word (skip). Both requests are
//   sampled only on the handshake edge.
//
//   Optional feature macro: FETCH_HALT_EN
//     When it is defined, a fetched word equal to HALT_OPC is not issued.
//     Instead the unit parks in HALTED until stop or reset.
//     When it is undefined, HALT_OPC is an ordinary instruction and halted
//     is tied to 0.
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous active-low reset
//     prog_we     program-memory write enable (IDLE only)
//     prog_addr   program-memory write address
//     prog_data   program-memory write data
//     start       begin fetching from address 0 (IDLE only)
//     stop        abort fetch, return to IDLE (wins over everything else)
//     jump        redirect PC to jump_addr on handshake
//     jump_addr   jump target
//     skip        discard next sequential word on handshake
//     inst_ready  decoder accepts inst_reg
//     inst_reg    current instruction to the decoder
//     inst_valid  inst_reg holds an unconsumed instruction
//     pc          address of the next word to fetch
//     busy        unit is not IDLE
//     halted      halt opcode reached (FETCH_HALT_EN only)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DEPTH    = 2**ADDR_W,
   parameter int unsigned       INST_W   = 8,
   parameter logic [INST_W-1:0] HALT_OPC = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [INST_W-1:0] prog_data,
   input  logic              start,
   input  logic              stop,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              skip,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_reg,
   output logic              inst_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INST_W-1:0]   inst_reg_q, inst_reg_d;
   logic                inst_valid_q, inst_valid_d;

   logic [INST_W-1:0]   mem [DEPTH];
   logic [INST_W-1:0]   fetch_word;
   logic                handshake;
   logic                is_halt;

   // -----------------------------------------------------------------------
   // Program memory
   // -----------------------------------------------------------------------
   // NOTE: the memory array has no reset. Clearing it would turn a RAM into
   // a register file, and the contents are defined to survive reset.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && prog_we) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // The word addressed by pc is captured into inst_reg at the end of FETCH.
   // That register is the one-cycle read latency. A write made on the
   // IDLE->FETCH edge is therefore already visible to the first fetch.
   assign fetch_word = mem[pc_q];
   assign handshake  = inst_valid_q && inst_ready;

`ifdef FETCH_HALT_EN
   assign is_halt = (fetch_word == HALT_OPC);
`else
   logic unused_halt_opc;
   assign unused_halt_opc = ^HALT_OPC;
   assign is_halt         = 1'b0;
`endif

   // -----------------------------------------------------------------------
   // State and datapath registers
   // -----------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         inst_reg_q   <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_reg_q   <= inst_reg_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   // NOTE: every combinational output gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (stop)         state_d = ST_IDLE;
            else if (is_halt) state_d = ST_HALTED;
            else              state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (stop)           state_d = ST_IDLE;
            else if (handshake) state_d = ST_FETCH;
         end
         ST_HALTED: begin
            if (stop) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // Datapath next values (pc, instruction register, valid flag)
   // -----------------------------------------------------------------------
   always_comb begin
      pc_d         = pc_q;
      inst_reg_d   = inst_reg_q;
      inst_valid_d = inst_valid_q;
      if (state_q != ST_IDLE && stop) begin
         // Abort: any pending instruction and a concurrent handshake are dropped.
         pc_d         = '0;
         inst_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               pc_d         = '0;
               inst_valid_d = 1'b0;
            end
            ST_FETCH: begin
               // A halt word is neither issued nor consumed, so pc keeps pointing at it.
               if (!is_halt) begin
                  inst_reg_d   = fetch_word;
                  inst_valid_d = 1'b1;
                  pc_d         = pc_q + ADDR_W'(1);
               end
            end
            ST_ISSUE: begin
               if (handshake) begin
                  inst_valid_d = 1'b0;
                  if (jump)      pc_d = jump_addr;
                  else if (skip) pc_d = pc_q + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   always_comb begin
      busy   = (state_q != ST_IDLE);
`ifdef FETCH_HALT_EN
      halted = (state_q == ST_HALTED);
`else
      halted = 1'b0;
`endif
   end

   assign inst_reg   = inst_reg_q;
   assign inst_valid = inst_valid_q;
   assign pc         = pc_q;

endmodule
